// File: rtl/ctrl_pipeline_if.sv
// Control bundle between the ID-stage decoder/datapath and ctrl_pipeline.
// The slave modport is the pipeline controller; the master modport is the decoder/datapath side.
interface ctrl_pipeline_if #(
    parameter int CNT_W = 16
);
    // ID-stage decoded instruction and EX-stage ALU flag
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_reg_dst;
    logic             id_alu_src;
    logic             id_branch;
    logic             id_b;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             id_jump;
    logic [3:0]       id_alu_ctrl;
    logic             ex_zero;

    // Hazard / PC control and per-stage controls
    logic             stall;
    logic             flush_ifid;
    logic [1:0]       pc_sel;
    logic             ex_alu_src;
    logic             ex_reg_dst;
    logic [3:0]       ex_alu_ctrl;
    logic             mem_write;
    logic             mem_read;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [4:0]       wb_waddr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_reg_dst, id_alu_src,
               id_branch, id_b, id_mem_write, id_mem_to_reg, id_jump, id_alu_ctrl, ex_zero,
        input  stall, flush_ifid, pc_sel, ex_alu_src, ex_reg_dst, ex_alu_ctrl, mem_write,
               mem_read, wb_reg_write, wb_mem_to_reg, wb_waddr, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_reg_dst, id_alu_src,
               id_branch, id_b, id_mem_write, id_mem_to_reg, id_jump, id_alu_ctrl, ex_zero,
        output stall, flush_ifid, pc_sel, ex_alu_src, ex_reg_dst, ex_alu_ctrl, mem_write,
               mem_read, wb_reg_write, wb_mem_to_reg, wb_waddr, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline with hazard detection, branch/jump resolution and forwarding selects.
// Optional macro FORWARDING_EN: with it only load-use stalls; without it every RAW on EX/MEM stalls.
module ctrl_pipeline #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_pipeline_if.slave   bus
);
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Stage registers
    logic             r_ex_valid, r_ex_reg_write, r_ex_alu_src, r_ex_reg_dst;
    logic             r_ex_branch, r_ex_b, r_ex_mem_write, r_ex_mem_to_reg;
    logic [3:0]       r_ex_alu_ctrl;
    logic [4:0]       r_ex_dest;
    logic [1:0]       r_ex_fwd_a, r_ex_fwd_b;
    logic             r_mem_valid, r_mem_reg_write, r_mem_mem_write, r_mem_mem_to_reg;
    logic [4:0]       r_mem_dest;
    logic             r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg;
    logic [4:0]       r_wb_dest;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic             w_uses_rs, w_uses_rt, w_ex_hit, w_hazard;
    logic             w_taken, w_stall, w_jump, w_flush, w_ex_load;
    logic [1:0]       w_pc_sel, w_fwd_a, w_fwd_b;
    logic [4:0]       w_id_dest;
    logic             w_id_reg_write;

    function automatic logic src_hit(input logic [4:0] src, input logic used, input logic [4:0] dest);
        return used && (src == dest) && (dest != 5'd0);
    endfunction

`ifdef FORWARDING_EN
    // Selects are resolved one cycle early: today's EX becomes MEM, today's MEM becomes WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic ex_wr,  input logic [4:0] ex_dest,
                                           input logic mem_wr, input logic [4:0] mem_dest);
        if (src != 5'd0 && ex_wr && ex_dest == src)        return FWD_MEM;
        else if (src != 5'd0 && mem_wr && mem_dest == src) return FWD_WB;
        else                                               return FWD_RF;
    endfunction
`else
    logic w_mem_hit;
`endif

    // stall holds PC and IF/ID for one cycle; flush_ifid turns IF/ID into a bubble at the next edge.
    always_comb begin
        w_uses_rs      = ~bus.id_jump;
        w_uses_rt      = ~bus.id_alu_src | bus.id_mem_write | bus.id_branch;
        w_ex_hit       = src_hit(bus.id_rs, w_uses_rs, r_ex_dest) | src_hit(bus.id_rt, w_uses_rt, r_ex_dest);
        w_id_dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        w_id_reg_write = bus.id_reg_write & (w_id_dest != 5'd0);
`ifdef FORWARDING_EN
        w_hazard = bus.id_valid & r_ex_valid & r_ex_mem_to_reg & w_ex_hit;
        w_fwd_a  = fwd_sel(bus.id_rs, r_ex_valid & r_ex_reg_write, r_ex_dest,
                           r_mem_valid & r_mem_reg_write, r_mem_dest);
        w_fwd_b  = fwd_sel(bus.id_rt, r_ex_valid & r_ex_reg_write, r_ex_dest,
                           r_mem_valid & r_mem_reg_write, r_mem_dest);
`else
        w_mem_hit = src_hit(bus.id_rs, w_uses_rs, r_mem_dest) | src_hit(bus.id_rt, w_uses_rt, r_mem_dest);
        w_hazard  = bus.id_valid & ((r_ex_valid & r_ex_reg_write & w_ex_hit) |
                                    (r_mem_valid & r_mem_reg_write & w_mem_hit));
        w_fwd_a   = FWD_RF;
        w_fwd_b   = FWD_RF;
`endif
        w_taken   = r_ex_valid & r_ex_branch & (bus.ex_zero ^ r_ex_b);
        w_stall   = w_hazard & ~w_taken;
        w_jump    = bus.id_valid & bus.id_jump & ~w_hazard & ~w_taken;
        w_flush   = w_taken | w_jump;
        w_pc_sel  = PC_SEQ;
        if (w_taken)     w_pc_sel = PC_BR;
        else if (w_jump) w_pc_sel = PC_JMP;
        // A jump, a squashed instruction or a stalled instruction all leave a bubble in EX.
        w_ex_load = bus.id_valid & ~bus.id_jump & ~w_taken & ~w_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid       <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_alu_src     <= 1'b0;
            r_ex_reg_dst     <= 1'b0;
            r_ex_branch      <= 1'b0;
            r_ex_b           <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_mem_to_reg  <= 1'b0;
            r_ex_alu_ctrl    <= 4'd0;
            r_ex_dest        <= 5'd0;
            r_ex_fwd_a       <= FWD_RF;
            r_ex_fwd_b       <= FWD_RF;
            r_mem_valid      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_dest       <= 5'd0;
            r_wb_valid       <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dest        <= 5'd0;
            r_stall_cnt      <= '0;
            r_flush_cnt      <= '0;
        end else begin
            r_ex_valid       <= w_ex_load;
            r_ex_reg_write   <= w_ex_load & w_id_reg_write;
            r_ex_alu_src     <= w_ex_load & bus.id_alu_src;
            r_ex_reg_dst     <= w_ex_load & bus.id_reg_dst;
            r_ex_branch      <= w_ex_load & bus.id_branch;
            r_ex_b           <= w_ex_load & bus.id_b;
            r_ex_mem_write   <= w_ex_load & bus.id_mem_write;
            r_ex_mem_to_reg  <= w_ex_load & bus.id_mem_to_reg;
            r_ex_alu_ctrl    <= w_ex_load ? bus.id_alu_ctrl : 4'd0;
            r_ex_dest        <= w_ex_load ? w_id_dest : 5'd0;
            r_ex_fwd_a       <= w_ex_load ? w_fwd_a : FWD_RF;
            r_ex_fwd_b       <= w_ex_load ? w_fwd_b : FWD_RF;
            r_mem_valid      <= r_ex_valid;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_dest       <= r_ex_dest;
            r_wb_valid       <= r_mem_valid;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dest        <= r_mem_dest;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.flush_ifid    = w_flush;
    assign bus.pc_sel        = w_pc_sel;
    assign bus.ex_alu_src    = r_ex_valid & r_ex_alu_src;
    assign bus.ex_reg_dst    = r_ex_valid & r_ex_reg_dst;
    assign bus.ex_alu_ctrl   = r_ex_valid ? r_ex_alu_ctrl : 4'd0;
    assign bus.fwd_a         = r_ex_valid ? r_ex_fwd_a : FWD_RF;
    assign bus.fwd_b         = r_ex_valid ? r_ex_fwd_b : FWD_RF;
    assign bus.mem_write     = r_mem_valid & r_mem_mem_write;
    assign bus.mem_read      = r_mem_valid & r_mem_mem_to_reg;
    assign bus.wb_reg_write  = r_wb_valid & r_wb_reg_write;
    assign bus.wb_mem_to_reg = r_wb_valid & r_wb_mem_to_reg;
    assign bus.wb_waddr      = r_wb_valid ? r_wb_dest : 5'd0;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline; expectations follow FORWARDING_EN when it is defined.
module tb_ctrl_pipeline;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ctrl_pipeline_if #(.CNT_W(CNT_W)) bus ();
    ctrl_pipeline #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic rdst, input logic asrc, input logic br, input logic b,
                         input logic mw, input logic m2r, input logic j, input logic [3:0] alu);
        bus.id_valid = v;      bus.id_rs = rs;           bus.id_rt = rt;        bus.id_rd = rd;
        bus.id_reg_write = rw; bus.id_reg_dst = rdst;    bus.id_alu_src = asrc; bus.id_branch = br;
        bus.id_b = b;          bus.id_mem_write = mw;    bus.id_mem_to_reg = m2r;
        bus.id_jump = j;       bus.id_alu_ctrl = alu;
    endtask

    task automatic op_nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask
    task automatic op_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] alu);
        drive(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu);
    endtask
    task automatic op_lw(input logic [4:0] rt, input logic [4:0] rs);
        drive(1'b1, rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
    endtask
    task automatic op_addi(input logic [4:0] rt, input logic [4:0] rs);
        drive(1'b1, rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
    endtask
    task automatic op_br(input logic [4:0] rs, input logic [4:0] rt, input logic is_bne);
        drive(1'b1, rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, is_bne, 1'b0, 1'b0, 1'b0, 4'h6);
    endtask
    task automatic op_j();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ex_zero = 1'b0;
        op_nop();
        repeat (2) tick();
        chk("rst_pc_sel", bus.pc_sel, 2'b00);
        chk("rst_wb_waddr", bus.wb_waddr, 5'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 4'd0);
        rst_n = 1'b1;
        tick();

        // Jump, fill all stages, then reset mid-stream
        op_j(); settle();
        chk("j_pc_sel", bus.pc_sel, 2'b10);
        chk("j_flush", bus.flush_ifid, 1'b1);
        chk("j_stall", bus.stall, 1'b0);
        tick();
        chk("j_flush_cnt", bus.flush_cnt, 4'd1);
        op_r(5'd3, 5'd1, 5'd2, 4'h2); tick();
        op_r(5'd4, 5'd1, 5'd2, 4'h2); tick();
        op_r(5'd6, 5'd1, 5'd2, 4'h2); tick();
        chk("fill_wb_we", bus.wb_reg_write, 1'b1);
        chk("fill_wb_waddr", bus.wb_waddr, 5'd3);
        chk("fill_ex_alu", bus.ex_alu_ctrl, 4'h2);
        op_r(5'd7, 5'd1, 5'd2, 4'h2);
        rst_n = 1'b0; settle();
        chk("mrst_wb_we", bus.wb_reg_write, 1'b0);
        chk("mrst_wb_waddr", bus.wb_waddr, 5'd0);
        chk("mrst_ex_alu", bus.ex_alu_ctrl, 4'h0);
        chk("mrst_ex_rdst", bus.ex_reg_dst, 1'b0);
        chk("mrst_flush_cnt", bus.flush_cnt, 4'd0);
        chk("mrst_stall", bus.stall, 1'b0);
        chk("mrst_pc_sel", bus.pc_sel, 2'b00);
        op_nop(); settle();
        rst_n = 1'b1;
        tick();

        // lw $2 then add $3,$2,$4
        op_lw(5'd2, 5'd1); settle();
        chk("lw_stall", bus.stall, 1'b0);
        tick();
        op_r(5'd3, 5'd2, 5'd4, 4'h2); settle();
        chk("lu_stall", bus.stall, 1'b1);
        chk("lu_flush", bus.flush_ifid, 1'b0);
        tick();
        chk("lu_bubble_rdst", bus.ex_reg_dst, 1'b0);
        chk("lu_mem_read", bus.mem_read, 1'b1);
        chk("lu_stall_cnt", bus.stall_cnt, 4'd1);
`ifdef FORWARDING_EN
        settle();
        chk("lu_release", bus.stall, 1'b0);
        tick();
        chk("lu_fwd_a", bus.fwd_a, 2'b01);
        chk("lu_fwd_b", bus.fwd_b, 2'b00);
        chk("lu_ex_rdst", bus.ex_reg_dst, 1'b1);
        chk("lu_wb_waddr", bus.wb_waddr, 5'd2);
        chk("lu_wb_m2r", bus.wb_mem_to_reg, 1'b1);
        chk("lu_stall_cnt2", bus.stall_cnt, 4'd1);
`else
        settle();
        chk("lu_stall2", bus.stall, 1'b1);
        tick();
        chk("lu_wb_waddr", bus.wb_waddr, 5'd2);
        chk("lu_wb_m2r", bus.wb_mem_to_reg, 1'b1);
        settle();
        chk("lu_release", bus.stall, 1'b0);
        tick();
        chk("lu_fwd_a", bus.fwd_a, 2'b00);
        chk("lu_ex_rdst", bus.ex_reg_dst, 1'b1);
        chk("lu_stall_cnt2", bus.stall_cnt, 4'd2);
`endif
        op_nop(); repeat (3) tick();

        // add $2 then sub $5,$2,$2
        op_r(5'd2, 5'd1, 5'd1, 4'h2); tick();
        op_r(5'd5, 5'd2, 5'd2, 4'h6); settle();
`ifdef FORWARDING_EN
        chk("raw_stall", bus.stall, 1'b0);
        tick();
        chk("raw_fwd_a", bus.fwd_a, 2'b10);
        chk("raw_fwd_b", bus.fwd_b, 2'b10);
        chk("raw_stall_cnt", bus.stall_cnt, 4'd1);
`else
        chk("raw_stall1", bus.stall, 1'b1);
        tick(); settle();
        chk("raw_stall2", bus.stall, 1'b1);
        tick(); settle();
        chk("raw_stall3", bus.stall, 1'b0);
        tick();
        chk("raw_fwd_a", bus.fwd_a, 2'b00);
        chk("raw_fwd_b", bus.fwd_b, 2'b00);
        chk("raw_ex_alu", bus.ex_alu_ctrl, 4'h6);
        chk("raw_stall_cnt", bus.stall_cnt, 4'd4);
`endif
        op_nop(); repeat (3) tick();

`ifdef FORWARDING_EN
        // Back-to-back writers of $11: the younger one (MEM) must win over WB
        op_r(5'd11, 5'd1, 5'd1, 4'h2); tick();
        op_r(5'd11, 5'd1, 5'd1, 4'h2); tick();
        op_r(5'd12, 5'd11, 5'd0, 4'h2); tick();
        chk("prio_fwd_a", bus.fwd_a, 2'b10);
        chk("prio_fwd_b", bus.fwd_b, 2'b00);
        op_nop(); repeat (3) tick();
`endif

        // lw $7; beq $1,$1 taken while ID holds a user of $7
        op_lw(5'd7, 5'd1); tick();
        op_br(5'd1, 5'd1, 1'b0); settle();
        chk("beq_id_stall", bus.stall, 1'b0);
        tick();
        bus.ex_zero = 1'b1;
        op_r(5'd8, 5'd7, 5'd7, 4'h2); settle();
        chk("br_pc_sel", bus.pc_sel, 2'b01);
        chk("br_flush", bus.flush_ifid, 1'b1);
        chk("br_stall", bus.stall, 1'b0);
        tick();
        bus.ex_zero = 1'b0;
        op_nop();
        chk("br_flush_cnt", bus.flush_cnt, 4'd1);
        chk("br_squash_alu", bus.ex_alu_ctrl, 4'h0);
`ifdef FORWARDING_EN
        chk("br_stall_cnt", bus.stall_cnt, 4'd1);
`else
        chk("br_stall_cnt", bus.stall_cnt, 4'd4);
`endif
        settle();
        chk("br_after_pc_sel", bus.pc_sel, 2'b00);
        op_nop(); repeat (3) tick();

        // j then add; bne not taken / taken
        op_j(); settle();
        chk("j2_pc_sel", bus.pc_sel, 2'b10);
        chk("j2_flush", bus.flush_ifid, 1'b1);
        tick();
        chk("j2_flush_cnt", bus.flush_cnt, 4'd2);
        op_r(5'd9, 5'd1, 5'd1, 4'h2); settle();
        chk("j2_add_pc_sel", bus.pc_sel, 2'b00);
        chk("j2_add_flush", bus.flush_ifid, 1'b0);
        tick();
        op_br(5'd1, 5'd2, 1'b1); tick();
        op_nop();
        bus.ex_zero = 1'b1; settle();
        chk("bne_nt_pc_sel", bus.pc_sel, 2'b00);
        chk("bne_nt_flush", bus.flush_ifid, 1'b0);
        bus.ex_zero = 1'b0; settle();
        chk("bne_t_pc_sel", bus.pc_sel, 2'b01);
        chk("bne_t_flush", bus.flush_ifid, 1'b1);
        tick();
        chk("bne_flush_cnt", bus.flush_cnt, 4'd3);
        op_nop(); repeat (3) tick();

        // addi $0,$0,5 then use $0
        op_addi(5'd0, 5'd0); tick();
        op_r(5'd10, 5'd0, 5'd0, 4'h2); settle();
        chk("r0_stall", bus.stall, 1'b0);
        tick();
        op_nop();
        chk("r0_fwd_a", bus.fwd_a, 2'b00);
        chk("r0_fwd_b", bus.fwd_b, 2'b00);
        tick();
        chk("r0_wb_we", bus.wb_reg_write, 1'b0);
        chk("r0_wb_waddr", bus.wb_waddr, 5'd0);
        repeat (3) tick();

        // 2^CNT_W+3 load-use stalls saturate stall_cnt
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            op_lw(5'd13, 5'd1); tick();
            op_r(5'd14, 5'd13, 5'd13, 4'h2); settle();
            chk("sat_stall", bus.stall, 1'b1);
            tick();
        end
        op_nop(); tick();
        chk("sat_stall_cnt", bus.stall_cnt, 4'hF);
        chk("sat_flush_cnt", bus.flush_cnt, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
